// File: rtl/aes_pkg.sv
// Shared AES widths, state/column types and FSM encoding for the round-pipeline stages.
package aes_pkg;

    localparam int AES_STATE_W = 128;
    localparam int AES_COL_W   = 32;
    localparam int AES_NCOLS   = 4;

    typedef logic [0:AES_STATE_W-1] aes_state_t;
    typedef logic [0:AES_COL_W-1]   aes_col_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } fsm_t;

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/mix_cols.sv
// Combinational AES MixColumns on one 32-bit column; byte 0 occupies the most significant bits.
module mix_cols
    import aes_pkg::*;
(
    input  aes_col_t col_in,
    output aes_col_t col_out
);

    logic [7:0] a0;
    logic [7:0] a1;
    logic [7:0] a2;
    logic [7:0] a3;

    assign a0 = col_in[0:7];
    assign a1 = col_in[8:15];
    assign a2 = col_in[16:23];
    assign a3 = col_in[24:31];

    // 3*b is computed as xtime(b) ^ b.
    assign col_out[0:7]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    assign col_out[8:15]  = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    assign col_out[16:23] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    assign col_out[24:31] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);

endmodule

// File: rtl/mix_cols_seq.sv
// Steps a 128-bit AES state through COLS_PER_CYCLE shared mix_cols columns per clock,
// with valid/ready on both sides, a final-round bypass and a synchronous abort.
module mix_cols_seq
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  aes_state_t in_state,
    input  logic       in_bypass,
    input  logic       abort,
    output logic       out_valid,
    input  logic       out_ready,
    output aes_state_t out_state,
    output logic       busy
);

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cpc
        $error("mix_cols_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    // A step of 4 truncates to 0, so the counter naturally wraps after every group.
    localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST_CNT = 2'(AES_NCOLS - COLS_PER_CYCLE);

    fsm_t       state;
    fsm_t       state_next;
    logic [1:0] col_cnt;
    aes_state_t src_q;
    aes_state_t res_q;
    logic       accept;

    logic [1:0] col_idx [COLS_PER_CYCLE];
    aes_col_t   col_src [COLS_PER_CYCLE];
    aes_col_t   col_mix [COLS_PER_CYCLE];

    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
        assign col_idx[g] = col_cnt + 2'(g);
        assign col_src[g] = src_q[{col_idx[g], 5'd0} +: AES_COL_W];

        mix_cols u_mix_cols (
            .col_in (col_src[g]),
            .col_out(col_mix[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Abort wins over every handshake, so in_ready is withheld during an abort cycle.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !abort;
            end
            RUN: begin
                if (col_cnt == LAST_CNT) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready && !abort;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (accept) begin
            state_next = in_bypass ? DONE : RUN;
        end
        if (abort) begin
            state_next = IDLE;
        end
    end

    assign accept    = in_valid && in_ready;
    assign busy      = (state != IDLE);
    assign out_state = (state == DONE) ? res_q : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_cnt <= '0;
            src_q   <= '0;
            res_q   <= '0;
        end else if (!abort) begin
            if (accept) begin
                src_q   <= in_state;
                col_cnt <= '0;
                if (in_bypass) begin
                    res_q <= in_state;
                end
            end else if (state == RUN) begin
                for (int g = 0; g < COLS_PER_CYCLE; g++) begin
                    res_q[{col_idx[g], 5'd0} +: AES_COL_W] <= col_mix[g];
                end
                col_cnt <= col_cnt + STEP;
            end
        end
    end

endmodule

// File: tb/tb_mix_cols_seq.sv
// Self-checking bench for mix_cols_seq: vector table, handshake corner cases and a
// scoreboarded random stream against a GF(2^8) matrix model.
module tb_mix_cols_seq;

    typedef logic [0:127] state_t;

    typedef struct {
        state_t din;
        logic   bypass;
        state_t expected;
        int     latency;
        string  name;
    } vec_t;

    localparam state_t FIPS_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam state_t FIPS_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam state_t T2_IN    = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
    localparam state_t T2_OUT   = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;
    localparam int     NBLK     = 1000;

    logic   clk = 1'b0;
    logic   rst;
    logic   in_valid;
    logic   in_bypass;
    logic   abort;
    logic   out_ready;
    state_t in_state;

    logic   in_ready_1, out_valid_1, busy_1;
    logic   in_ready_2, out_valid_2, busy_2;
    logic   in_ready_4, out_valid_4, busy_4;
    state_t out_state_1, out_state_2, out_state_4;

    int     tests = 0;
    int     failures = 0;
    state_t sbq[$];
    vec_t   vecs[5];

    always #5 clk = ~clk;

    mix_cols_seq #(.COLS_PER_CYCLE(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_1),
        .in_state(in_state), .in_bypass(in_bypass), .abort(abort),
        .out_valid(out_valid_1), .out_ready(out_ready), .out_state(out_state_1), .busy(busy_1)
    );

    mix_cols_seq #(.COLS_PER_CYCLE(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_2),
        .in_state(in_state), .in_bypass(in_bypass), .abort(abort),
        .out_valid(out_valid_2), .out_ready(out_ready), .out_state(out_state_2), .busy(busy_2)
    );

    mix_cols_seq #(.COLS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_4),
        .in_state(in_state), .in_bypass(in_bypass), .abort(abort),
        .out_valid(out_valid_4), .out_ready(out_ready), .out_state(out_state_4), .busy(busy_4)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    // MixColumns as the FIPS-197 circulant matrix product.
    function automatic state_t goldenModel(input state_t s, input logic bypass);
        logic [7:0] coef [4] = '{8'h02, 8'h03, 8'h01, 8'h01};
        logic [7:0] a [4];
        logic [7:0] acc;
        state_t r = '0;
        if (bypass) return s;
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++) a[j] = s[32*c + 8*j +: 8];
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) acc = acc ^ gmul(a[j], coef[(j - row + 4) % 4]);
                r[32*c + 8*row +: 8] = acc;
            end
        end
        return r;
    endfunction

    task automatic checkVal(input string name, input state_t act, input state_t exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %b, required %b", name, act, exp);
        end
    endtask

    task automatic checkInt(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic popCheck(input string name, input state_t act);
        if (sbq.size() == 0) begin
            tests++;
            failures++;
            $display("[TB] FAIL %s: output %h with empty scoreboard", name, act);
        end else begin
            checkVal(name, act, sbq.pop_front());
        end
    endtask

    // Called at negedge+1 just after the accept edge has been scheduled; counts cycles to out_valid.
    task automatic waitOutput(output int lat);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        #1;
        while (!out_valid_1 && lat < 20) begin
            @(negedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic applyStimulus(input vec_t v, output int lat);
        @(negedge clk);
        in_state  = v.din;
        in_bypass = v.bypass;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        #1;
        checkBit({v.name, " in_ready"}, in_ready_1, 1'b1);
        sbq.push_back(v.expected);
        waitOutput(lat);
    endtask

    task automatic checkOutput(input string name, input int exp_lat, input int lat);
        checkInt({name, " latency"}, lat, exp_lat);
        popCheck({name, " out_state"}, out_state_1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int lat1, lat2, lat4;
        int sent, got, cyc;
        logic seen;
        logic taken;
        vec_t v;

        vecs[0] = '{FIPS_IN, 1'b0, FIPS_OUT, 5, "fips"};
        vecs[1] = '{T2_IN,   1'b0, T2_OUT,   5, "vec2"};
        vecs[2] = '{FIPS_IN, 1'b1, FIPS_IN,  1, "fips_bypass"};
        vecs[3] = '{T2_IN,   1'b1, T2_IN,    1, "vec2_bypass"};
        vecs[4] = '{128'h0,  1'b0, 128'h0,   5, "zero"};

        rst = 1'b1; in_valid = 1'b0; in_bypass = 1'b0; abort = 1'b0; out_ready = 1'b0;
        in_state = '0;
        @(negedge clk);
        #1;
        checkBit("reset out_valid", out_valid_1, 1'b0);
        checkVal("reset out_state", out_state_1, '0);
        checkBit("reset busy", busy_1, 1'b0);
        rst = 1'b0;
        #1;
        checkBit("post-reset in_ready", in_ready_1, 1'b1);

        // All three column widths on the same block.
        @(negedge clk);
        in_state = T2_IN; in_bypass = 1'b0; in_valid = 1'b1;
        #1;
        checkBit("cpc2 in_ready", in_ready_2, 1'b1);
        checkBit("cpc4 in_ready", in_ready_4, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        lat1 = 0; lat2 = 0; lat4 = 0;
        for (int c = 1; c <= 10; c++) begin
            #1;
            if (out_valid_1 && lat1 == 0) lat1 = c;
            if (out_valid_2 && lat2 == 0) lat2 = c;
            if (out_valid_4 && lat4 == 0) lat4 = c;
            @(negedge clk);
        end
        checkInt("cpc1 latency", lat1, 5);
        checkInt("cpc2 latency", lat2, 3);
        checkInt("cpc4 latency", lat4, 2);
        checkVal("cpc1 out_state", out_state_1, T2_OUT);
        checkVal("cpc2 out_state", out_state_2, T2_OUT);
        checkVal("cpc4 out_state", out_state_4, T2_OUT);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i], lat);
            checkOutput(vecs[i].name, vecs[i].latency, lat);
        end

        // Stall in DONE for 10 cycles while a new block waits, then take it on the release cycle.
        applyStimulus(vecs[0], lat);
        checkInt("stall first latency", lat, 5);
        in_state = T2_IN; in_bypass = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            checkVal("stall out_state", out_state_1, FIPS_OUT);
            checkBit("stall in_ready", in_ready_1, 1'b0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        checkBit("release in_ready", in_ready_1, 1'b1);
        popCheck("release out_state", out_state_1);
        sbq.push_back(T2_OUT);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b0;
        lat = 1;
        #1;
        while (!out_valid_1 && lat < 20) begin
            @(negedge clk);
            #1;
            lat++;
        end
        checkOutput("back-to-back", 5, lat);

        // Abort in the second RUN cycle.
        @(negedge clk);
        in_state = FIPS_IN; in_bypass = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #1;
        checkBit("abort busy", busy_1, 1'b0);
        checkBit("abort in_ready", in_ready_1, 1'b1);
        seen = out_valid_1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            seen = seen | out_valid_1;
        end
        checkBit("abort out_valid never rises", seen, 1'b0);
        applyStimulus(vecs[0], lat);
        checkOutput("after abort", 5, lat);

        // Asynchronous reset mid-RUN.
        @(negedge clk);
        in_state = T2_IN; in_bypass = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkBit("mid-run rst busy", busy_1, 1'b0);
        checkBit("mid-run rst out_valid", out_valid_1, 1'b0);
        checkVal("mid-run rst out_state", out_state_1, '0);
        #4;
        rst = 1'b0;
        @(negedge clk);
        #1;
        checkBit("rst release in_ready", in_ready_1, 1'b1);

        // Random stream against the model.
        sent = 0; got = 0; cyc = 0; taken = 1'b0;
        while (got < NBLK && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            if (taken) in_valid = 1'b0;
            taken = 1'b0;
            if (!in_valid && sent < NBLK && $urandom_range(3) != 0) begin
                in_state  = {$urandom, $urandom, $urandom, $urandom};
                in_bypass = ($urandom_range(3) == 0);
                in_valid  = 1'b1;
            end
            out_ready = ($urandom_range(3) != 0);
            #1;
            if (in_valid && in_ready_1) begin
                sbq.push_back(goldenModel(in_state, in_bypass));
                sent++;
                taken = 1'b1;
            end
            if (out_valid_1 && out_ready) begin
                popCheck("stream out_state", out_state_1);
                got++;
            end
        end
        checkInt("stream blocks received", got, NBLK);
        checkInt("stream scoreboard empty", sbq.size(), 0);
        in_valid = 1'b0;
        out_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
